// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: valid/ready byte intake, power-of-two FIFO, LSB-first serialiser.
// Optional even-parity bit compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_buf #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 115200,
  parameter int FIFO_DEPTH = 16,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          uart_txd,
  output logic          busy,
  output logic [LW-1:0] fifo_level
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW      = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BPS_CNT - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level, w_level_nxt;
  logic          w_push, w_pop, w_empty, w_full;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_tick;
  logic          r_txd, w_txd_nxt;
  logic          r_busy;

  assign w_full     = (r_level == LVL_FULL);
  assign w_empty    = (r_level == '0);
  assign w_push     = tx_valid && !w_full;
  assign w_tick     = (r_cnt == CNT_MAX);
  assign tx_ready   = !w_full;
  assign uart_txd   = r_txd;
  assign busy       = r_busy;
  assign fifo_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
  end

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + LW'(1);
    else if (!w_push && w_pop) w_level_nxt = r_level - LW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= w_level_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rptr];
          w_idx_nxt   = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_tick) begin
          w_cnt_nxt = '0;
          // Reload straight into START so queued frames run back to back.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rptr];
            w_idx_nxt   = '0;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line level is registered from the next state so START appears right after the load edge.
  always_comb begin
    w_txd_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = w_shift_nxt[w_idx_nxt];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_txd_nxt = ^w_shift_nxt;
`endif
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
      r_busy  <= (w_state_nxt != S_IDLE) || (w_level_nxt != '0);
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf: accepted bytes are queued as expectations, a line
// monitor decodes frames and compares. Define UART_TX_PARITY_EN for the parity build.
module tb_uart_tx_buf;

  localparam int BPS = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * BPS;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_txd;
  logic       busy;
  logic [4:0] fifo_level;

  uart_tx_buf #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .uart_txd(uart_txd), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  bit         mon_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Line monitor: every clock of every bit must hold the same level.
  initial begin : monitor
    logic [10:0] bits;
    bit          glitch, aborted;
    logic [7:0]  exp;
    forever begin
      forever begin
        @(negedge clk);
        if (!rst && uart_txd === 1'b0) break;
      end
      mon_active = 1'b1;
      start_q.push_back(cyc);
      glitch = 1'b0; aborted = 1'b0; bits = '1;
      for (int i = 0; i < NB * BPS; i++) begin
        if (i > 0) @(negedge clk);
        if (rst) begin aborted = 1'b1; break; end
        if (i % BPS == 0) bits[i / BPS] = uart_txd;
        else if (uart_txd !== bits[i / BPS]) glitch = 1'b1;
      end
      if (!aborted) begin
        chk("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          chk("rx_byte", bits[8:1], exp);
`ifdef UART_TX_PARITY_EN
          chk("parity_bit", bits[9], ^exp);
`endif
          chk("framing", {glitch, bits[0], bits[NB-1]}, 3'b001);
        end
      end
      mon_active = 1'b0;
    end
  end

  task automatic push(input logic [7:0] b, output int e, output bit acc);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    acc      = tx_ready;
    e        = cyc + 1;
    @(posedge clk);
    if (acc) exp_q.push_back(b);
  endtask

  task automatic idle_in;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0 || mon_active) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, n < 20000, 1);
  endtask

  initial begin : stim
    int         e, e0, eN, n, acc_n, win;
    bit         acc, started;
    logic [7:0] nb;

    rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_txd", uart_txd, 1);
    chk("reset_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_level", fifo_level, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0x57: start right after the load edge, busy clears one frame later.
    start_q.delete();
    push(8'h57, e, acc);
    chk("single_accept", acc, 1);
    idle_in();
    chk("single_level1", fifo_level, 1);
    chk("single_txd_pre", uart_txd, 1);
    n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    chk("single_busy_fall", cyc, e + 1 + FRAME);
    chk("single_level0", fifo_level, 0);
    chk("single_start_cnt", start_q.size(), 1);
    if (start_q.size() != 0) chk("single_start_edge", start_q[0], e + 1);
    wait_idle("single");

    // Back-to-back: three frames with no idle clock between them.
    start_q.delete();
    push(8'h41, e, acc);
    push(8'h42, e, acc);
    push(8'h43, e, acc);
    idle_in();
    wait_idle("b2b");
    chk("b2b_starts", start_q.size(), 3);
    if (start_q.size() == 3) begin
      chk("b2b_gap1", start_q[1] - start_q[0], FRAME);
      chk("b2b_gap2", start_q[2] - start_q[1], FRAME);
    end

    // 0x03 has even parity 0; 0x57 above has parity 1.
    push(8'h03, e, acc);
    idle_in();
    wait_idle("x03");

    // Push during a frame: next frame starts directly after the stop bit.
    start_q.delete();
    push(8'h55, e, acc);
    idle_in();
    repeat (40) @(negedge clk);
    push(8'hAA, e, acc);
    idle_in();
    wait_idle("midpush");
    chk("midpush_starts", start_q.size(), 2);
    if (start_q.size() == 2) chk("midpush_gap", start_q[1] - start_q[0], FRAME);

    // Full queue with tx_valid held and an incrementing byte.
    acc_n = 0; win = 0; started = 1'b0; nb = 8'h00; eN = 0;
    for (int it = 0; it < 8000 && acc_n < 40; it++) begin
      @(negedge clk);
      if (started && cyc == eN + 15) begin
        chk("full_level15", fifo_level, 15);
        chk("full_ready15", tx_ready, 1);
      end
      if (started && cyc == eN + 16) begin
        chk("full_level16", fifo_level, 16);
        chk("full_ready16", tx_ready, 0);
      end
      if (started && cyc == eN + 19) chk("full_accepts", acc_n, 17);
      tx_valid = 1'b1;
      tx_data  = nb;
      acc      = tx_ready;
      e        = cyc + 1;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(nb);
        if (!started) begin started = 1'b1; eN = e; end
        if (e >= eN + 20 && e <= eN + 319) win++;
        acc_n++;
        nb++;
      end
    end
    idle_in();
    chk("full_total", acc_n, 40);
    chk("full_per_frame", win, 3);
    wait_idle("full");

    // Reset during data bit 3 of 0x10 with five bytes still queued.
    push(8'h10, e0, acc);
    for (int k = 1; k < 6; k++) push(8'h10 + 8'(k), e, acc);
    idle_in();
    while (cyc < e0 + 45) @(negedge clk);
    chk("pre_reset_line", uart_txd, 0);
    chk("pre_reset_level", fifo_level, 5);
    #2 rst = 1'b1;
    #1;
    chk("rst_txd", uart_txd, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push(8'h55, e, acc);
    idle_in();
    wait_idle("post_reset");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
# uart_tx_buf

Buffered UART transmitter for the verification platform's host link: accepts bytes from the AES result/status path over a valid/ready handshake, queues them in a small synchronous FIFO, and serialises them as 8N1 frames (LSB first) on `uart_txd`. It is the return-direction counterpart of the platform's UART command receiver, sharing its bit-timing scheme and parameters.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `UART_BPS`, default 115200: line baud rate.
- `FIFO_DEPTH`, default 16: byte capacity of the queue; must be a power of two and at least 2.
- Derived: `BPS_CNT = CLK_FREQ/UART_BPS`, using integer division. Each bit lasts exactly `BPS_CNT` clocks.
- Derived: `LW = clog2(FIFO_DEPTH)+1`.
- `clk`, in, 1: single clock domain, rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `tx_data`, in, 8: byte to enqueue.
- `tx_valid`, in, 1: `tx_data` is valid.
- `tx_ready`, out, 1: queue can accept a byte; equals `!full`.
- `uart_txd`, out, 1: serial output; idles high.
- `busy`, out, 1: high while the FSM is not in IDLE or the queue is non-empty.
- `fifo_level`, out, `LW`: number of bytes queued, from 0 to `FIFO_DEPTH`.

## Operation
- Push: when `tx_valid && tx_ready` is high at a rising edge, `tx_data` is written and `fifo_level` increments.
  - When full, `tx_ready` is 0 and no push occurs, even if a pop happens in the same cycle.
- Pop: the FSM reads the head byte into the shift register and pops it in the same cycle.
  - Push and pop in the same cycle leave `fifo_level` unchanged, and data is preserved.
  - Write and read pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, PARITY (only with the macro defined), STOP.
  - IDLE: `uart_txd` is 1. If the queue is non-empty, load and pop the head, clear the bit counter and the bit index, then go to START.
  - START: `uart_txd` is 0 for `BPS_CNT` clocks, then go to DATA.
  - DATA: `uart_txd` = `shift[idx]` with `idx` running 0..7. Each bit lasts `BPS_CNT` clocks. After bit 7, go to PARITY or STOP.
  - PARITY: see Configuration.
  - STOP: `uart_txd` is 1 for `BPS_CNT` clocks. At the end of the stop bit:
    - if the queue is non-empty, load and pop the head and go directly to START, so frames are contiguous with no idle gap;
    - otherwise go to IDLE.
- The bit counter runs 0..`BPS_CNT`-1 and advances state on the terminal count.
- The FSM never modifies a byte after loading it. A push during a frame does not affect that frame.
- Reset values: `uart_txd`=1, `tx_ready`=1, `busy`=0, `fifo_level`=0, FSM=IDLE, pointers=0.
  - Reset asserted mid-frame forces `uart_txd` high immediately (asynchronously) and discards the queue contents.

## Timing
- A byte accepted at edge N into an empty queue while the FSM is IDLE:
  - the FIFO is visible as non-empty after edge N;
  - the pop/load happens at edge N+1;
  - `uart_txd` falls (START) after edge N+1.
- Frame length: 10·`BPS_CNT` clocks, or 11·`BPS_CNT` clocks with parity.
- `tx_ready` reasserts in the cycle after the pop that takes the queue from full to non-full.
- `busy` falls in the cycle the FSM enters IDLE with an empty queue.
- All outputs are registered except `tx_ready`, which is decoded from the registered `fifo_level`.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined: a PARITY state follows DATA bit 7.
  - `uart_txd` = XOR of the 8 data bits (even parity) for `BPS_CNT` clocks.
  - Frame is 11 bits.
- Undefined: the PARITY state and its logic are not compiled, and frames are 10 bits.

## Test plan
Bench parameters for all scenarios: `CLK_FREQ`=1_000_000, `UART_BPS`=100_000, so `BPS_CNT`=10.
- Single byte: push 0x57 ("W") once.
  - Line shows low 10 clocks, then bits 1,1,1,0,1,0,1,0 (10 clocks each), then high.
  - `busy` drops exactly 100 clocks after the start edge; `fifo_level` returns to 0.
- Back-to-back: push 0x41, 0x42, 0x43 in three consecutive cycles.
  - Three contiguous frames over 300 clocks with no idle clock between a stop bit and the next start bit.
  - Decoded bytes arrive in order.
- Full queue: hold `tx_valid` high with an incrementing byte starting at 0x00.
  - `tx_ready` goes low once `fifo_level`=16.
  - Afterwards exactly one byte is accepted per 100-clock frame.
  - The first 40 bytes are decoded as 0x00..0x27 in order, with none lost or duplicated.
- Reset mid-frame: assert `rst` at bit 3 of a frame with 5 bytes queued.
  - `uart_txd`=1 and `fifo_level`=0 immediately; `tx_ready`=1; `busy`=0.
  - After release, a new 0x55 push produces a clean frame.
- Parity build (`UART_TX_PARITY_EN` defined):
  - push 0x57 → parity bit 1 (five ones), 110-clock frame;
  - push 0x03 → parity bit 0.
- Push while transmitting: push 0xAA mid-frame of 0x55.
  - The 0x55 frame is unchanged.
  - The 0xAA frame starts immediately after the 0x55 stop bit.
